// File: rtl/ram_rd_pkg.sv
// Shared types and constants for the RAM stream reader.
// Optional feature macro: RAM_RD_CHECKSUM_EN (see ram_stream_reader).
package ram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ram_rd_state_t;

    localparam int RD_LATENCY = 1;
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs RAM read data ahead of the stream port.
// Push while full is accepted only when a pop happens in the same cycle.
module ram_rd_skid_fifo
    import ram_rd_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occupancy,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count < 2'(SKID_DEPTH)) || do_pop);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        occupancy = count;
        valid     = (count != 2'd0);
        head      = mem[rd_ptr];
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a contiguous RAM address range and streams the words out on valid/ready.
// Define RAM_RD_CHECKSUM_EN to add an XOR checksum of the delivered words.
module ram_stream_reader
    import ram_rd_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
`ifdef RAM_RD_CHECKSUM_EN
    ,
    output logic [DWIDTH-1:0] checksum
`endif
);

    ram_rd_state_t     state;
    ram_rd_state_t     state_next;
    logic [AWIDTH-1:0] addr_cnt;
    logic [AWIDTH:0]   remaining;
    logic              inflight;
    logic              inflight_last;
    logic              done_r;
    logic              accept;
    logic              issue;
    logic              pop;
    logic              final_pop;
    logic              rem_is_one;
    logic [1:0]        occupancy;
    logic              fifo_valid;
    logic [DWIDTH:0]   head;

    // Issue only if the FIFO can still hold everything already requested.
    always_comb begin
        accept     = (state == IDLE) && start;
        pop        = fifo_valid && m_ready;
        final_pop  = pop && head[DWIDTH];
        rem_is_one = (remaining == (AWIDTH+1)'(1));
        issue      = (state == RUN) && (remaining != '0) &&
                     (({1'b0, occupancy} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && (len != '0)) state_next = RUN;
            RUN:     if (issue && rem_is_one)  state_next = DRAIN;
            DRAIN:   if (final_pop)            state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = done_r;
        ram_we   = 1'b0;
        ram_addr = addr_cnt;
        m_valid  = fifo_valid;
        m_data   = head[DWIDTH-1:0];
        m_last   = fifo_valid && head[DWIDTH];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            addr_cnt      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && rem_is_one;
            done_r        <= (accept && (len == '0)) || ((state == DRAIN) && final_pop);
            if (accept && (len != '0)) begin
                addr_cnt  <= start_addr;
                remaining <= len;
            end else if (issue) begin
                addr_cnt  <= addr_cnt + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    ram_rd_skid_fifo #(
        .WIDTH(DWIDTH + 1)
    ) u_skid (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (inflight),
        .push_data({inflight_last, ram_dout}),
        .pop      (pop),
        .occupancy(occupancy),
        .valid    (fifo_valid),
        .head     (head)
    );

`ifdef RAM_RD_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum ^ head[DWIDTH-1:0];
        end
    end
`endif

endmodule
